// File: rtl/rtc_bus_driver_pkg.sv
// Shared definitions for the RTC multiplexed-bus controller: state encoding,
// default phase length and phase-counter width.
package rtc_bus_driver_pkg;

  localparam int T_PHASE_DEF = 4;
  localparam int CNT_W       = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    A_SETUP  = 3'd1,
    A_STROBE = 3'd2,
    A_HOLD   = 3'd3,
    D_SETUP  = 3'd4,
    D_STROBE = 3'd5,
    D_HOLD   = 3'd6,
    RECOVER  = 3'd7
  } rtc_state_e;

  function automatic rtc_state_e next_phase(input rtc_state_e s);
    case (s)
      A_SETUP:  return A_STROBE;
      A_STROBE: return A_HOLD;
      A_HOLD:   return D_SETUP;
      D_SETUP:  return D_STROBE;
      D_STROBE: return D_HOLD;
      D_HOLD:   return RECOVER;
      default:  return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_driver_phase_timer.sv
// Loadable down-counter timing one bus phase; tc is high on the last cycle.
module rtc_bus_driver_phase_timer
  import rtc_bus_driver_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/rtc_bus_driver.sv
// Bus master for a multiplexed address/data RTC: address phase, data phase and
// recovery, each phase T_PHASE cycles, with all bus controls driven from flops.
module rtc_bus_driver
  import rtc_bus_driver_pkg::*;
#(
  parameter int T_PHASE = T_PHASE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       a_d,
  output logic       cs,
  output logic       rd,
  output logic       wr,
  inout  wire  [7:0] dato
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(T_PHASE - 1);

  rtc_state_e state_q, state_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d, wdata_q, wdata_d, dout_q, dout_d;
  logic [7:0] rdata_q, rdata_d;
  logic       done_q, done_d;
  logic       a_d_q, a_d_d, cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, oe_q, oe_d;
  logic       tc, load;

  rtc_bus_driver_phase_timer u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (LOAD_VAL),
    .tc       (tc)
  );

  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = A_SETUP;
        rw_d    = rw;
        addr_d  = addr;
        wdata_d = wdata;
      end
    end else if (tc) begin
      state_d = next_phase(state_q);
      done_d  = (state_q == RECOVER);
      if (state_q == D_STROBE && rw_q) begin
        rdata_d = dato;
      end
    end
    load = (state_d != state_q);

    // Bus controls are decoded from the state being entered so they change
    // on the same edge as the state register.
    a_d_d  = 1'b1;
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    oe_d   = 1'b0;
    dout_d = addr_d;
    case (state_d)
      A_SETUP, A_HOLD: begin
        a_d_d = 1'b0;
        oe_d  = 1'b1;
      end
      A_STROBE: begin
        a_d_d = 1'b0;
        oe_d  = 1'b1;
        cs_d  = 1'b0;
        wr_d  = 1'b0;
      end
      D_SETUP, D_HOLD: begin
        oe_d   = !rw_d;
        dout_d = wdata_d;
      end
      D_STROBE: begin
        oe_d   = !rw_d;
        dout_d = wdata_d;
        cs_d   = 1'b0;
        if (rw_d) rd_d = 1'b0;
        else      wr_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      a_d_q   <= 1'b1;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      a_d_q   <= a_d_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      oe_q    <= oe_d;
    end
  end

  // Captured request and bus data need no reset: they are only observed behind oe_q/state.
  always_ff @(posedge clk) begin
    rw_q    <= rw_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    dout_q  <= dout_d;
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign rdata = rdata_q;
  assign a_d   = a_d_q;
  assign cs    = cs_q;
  assign rd    = rd_q;
  assign wr    = wr_q;
  assign dato  = oe_q ? dout_q : 8'hzz;

endmodule

// File: tb/tb_rtc_bus_driver.sv
// Directed bench for rtc_bus_driver: table of complete transactions checked
// cycle by cycle, plus busy-ignore, back-to-back and reset-abort sequences.
module tb_rtc_bus_driver;
  import rtc_bus_driver_pkg::*;

  localparam int T   = T_PHASE_DEF;
  localparam int TXN = 7 * T;
  localparam logic [7:0] PROBE = 8'h5A;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, a_d, cs, rd, wr;
  logic [7:0] rdata;
  wire  [7:0] dato;

  // RTC model: answers while rd is low; probe drives a marker to prove release.
  logic       probe = 1'b0;
  logic [7:0] rd_val = 8'h37;
  assign dato = (!rd) ? rd_val : (probe ? PROBE : 8'hzz);

  int n_chk = 0;
  int n_fail = 0;

  rtc_bus_driver #(.T_PHASE(T)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .rw    (rw),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .rdata (rdata),
    .a_d   (a_d),
    .cs    (cs),
    .rd    (rd),
    .wr    (wr),
    .dato  (dato)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // Strobe sanity on every cycle: never both strobes low, and cs low exactly when a strobe is low.
  always @(negedge clk) begin
    if (reset) begin
      n_chk++;
      if ((!rd && !wr) || (cs != (rd & wr))) begin
        n_fail++;
        $display("FAIL strobe_rule: got cs=%b rd=%b wr=%b required rd/wr not both 0 and cs=rd&wr",
                 cs, rd, wr);
      end
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_ctl(input string name, input logic [5:0] exp);
    n_chk++;
    if ({busy, done, a_d, cs, rd, wr} !== exp) begin
      n_fail++;
      $display("FAIL %s: got busy/done/a_d/cs/rd/wr=%b required %b",
               name, {busy, done, a_d, cs, rd, wr}, exp);
    end
  endtask

  task automatic expect_released(input string name);
    probe = 1'b1;
    #1;
    check8(name, dato, PROBE);
    probe = 1'b0;
  endtask

  task automatic run_txn(input logic r, input logic [7:0] a, input logic [7:0] w,
                         input logic [7:0] rv, input logic [7:0] exp_rdata, input string tag);
    logic [5:0] exp;
    @(negedge clk);
    rw = r; addr = a; wdata = w; rd_val = rv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= TXN; c++) begin
      int p;
      p = (c - 1) / T;
      @(negedge clk);
      exp = {1'b1, 1'b0, (p >= 3), !(p == 1 || p == 4), !(p == 4 && r),
             !(p == 1 || (p == 4 && !r))};
      check_ctl($sformatf("%s c%0d ctl", tag, c), exp);
      if (p < 3)                check8($sformatf("%s c%0d addr_bus", tag, c), dato, a);
      else if (p < 6 && !r)     check8($sformatf("%s c%0d wdata_bus", tag, c), dato, w);
      else if (p == 4)          check8($sformatf("%s c%0d rd_bus", tag, c), dato, rv);
      else                      expect_released($sformatf("%s c%0d released", tag, c));
    end
    @(negedge clk);
    check_ctl($sformatf("%s done_cycle", tag), 6'b011111);
    check8($sformatf("%s rdata", tag), rdata, exp_rdata);
    expect_released($sformatf("%s idle_released", tag));
    @(negedge clk);
    check_ctl($sformatf("%s after_done", tag), 6'b001111);
  endtask

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd_val;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];
  int   dones;

  initial begin
    vecs[0] = '{rw: 1'b0, addr: 8'h21, wdata: 8'h45, rd_val: 8'h37, exp_rdata: 8'h00};
    vecs[1] = '{rw: 1'b1, addr: 8'h22, wdata: 8'h00, rd_val: 8'h37, exp_rdata: 8'h37};
    vecs[2] = '{rw: 1'b0, addr: 8'h10, wdata: 8'hFF, rd_val: 8'h37, exp_rdata: 8'h37};
    vecs[3] = '{rw: 1'b1, addr: 8'h80, wdata: 8'h00, rd_val: 8'hAA, exp_rdata: 8'hAA};
    vecs[4] = '{rw: 1'b0, addr: 8'h00, wdata: 8'h00, rd_val: 8'hAA, exp_rdata: 8'hAA};

    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_ctl("reset ctl", 6'b001111);
    check8("reset rdata", rdata, 8'h00);
    expect_released("reset released");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rd_val, vecs[i].exp_rdata,
              $sformatf("vec%0d", i));
    end

    // Start pulsed at cycle 10 of a write must be ignored.
    @(negedge clk);
    rw = 1'b0; addr = 8'h33; wdata = 8'h66; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int c = 1; c <= TXN + 6; c++) begin
      @(negedge clk);
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      if (done) dones++;
      if (c == TXN + 1) check_ctl("ignore done_cycle", 6'b011111);
    end
    check8("ignore done_count", 8'(dones), 8'd1);
    check_ctl("ignore idle_after", 6'b001111);

    // Start held high: the next read begins right after the done cycle.
    @(negedge clk);
    rw = 1'b1; addr = 8'h44; rd_val = 8'h5C; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 2 * TXN + 2; c++) begin
      @(negedge clk);
      if (c == TXN + 1) begin
        check_ctl("b2b first_done", 6'b011111);
        check8("b2b first_rdata", rdata, 8'h5C);
        rd_val = 8'hC3;
      end
      if (c == TXN + 2) check_ctl("b2b second_a_setup", 6'b100111);
      if (c == 2 * TXN + 2) begin
        check_ctl("b2b second_done", 6'b011111);
        check8("b2b second_rdata", rdata, 8'hC3);
        start = 1'b0;
      end
    end
    @(negedge clk);
    check_ctl("b2b idle_after", 6'b001111);

    // Reset asserted in the middle of the write data strobe.
    @(negedge clk);
    rw = 1'b0; addr = 8'h21; wdata = 8'h45; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4 * T + 2) @(negedge clk);
    check_ctl("abort pre_strobe", 6'b101010);
    #1 reset = 1'b0;
    #1;
    check_ctl("abort ctl", 6'b001111);
    check8("abort rdata", rdata, 8'h00);
    expect_released("abort released");
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < TXN + 8; c++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check8("abort no_done", 8'(dones), 8'd0);
    check_ctl("abort idle_after", 6'b001111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
